// File: rtl/gpio_ctrl_if.sv
// gpio_ctrl_if: data-memory bus between the core (master) and the GPIO register block (slave).
interface gpio_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int AWIDTH = 32
);
    logic [AWIDTH-1:0] addr;
    logic [XLEN-1:0]   wdata;
    logic [2:0]        we;
    logic [XLEN-1:0]   rdata;
    logic              hit;
    modport master (output addr, wdata, we, input rdata, hit);
    modport slave (input addr, wdata, we, output rdata, hit);
endinterface

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: 8-bit GPIO register block (OUT/DIR/IN/EDGE/IRQ_MASK) on a 32-byte bus window.
// Define GPIO_IRQ_EN to build IRQ_MASK and irq; otherwise both are tied to 0.
module gpio_ctrl #(
    parameter int                XLEN      = 32,
    parameter int                AWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0000_8000
) (
    input  logic       clk,
    input  logic       rst,
    gpio_ctrl_if.slave bus,
    input  logic [7:0] gpio_in,
    output logic [7:0] gpio_out,
    output logic [7:0] gpio_oe,
    output logic       irq
);
    logic            sel, wr, hit_r;
    logic [2:0]      idx;
    logic [7:0]      out_r, dir_r, edge_r, mask_r, sync1, sync2, prev, rd_val, rise, clr;
    logic [XLEN-1:0] rdata_r;
    logic            unused_bits;

    assign sel         = bus.addr[AWIDTH-1:5] == BASE_ADDR[AWIDTH-1:5];
    assign idx         = bus.addr[4:2];
    assign wr          = sel && (bus.we == 3'b001 || bus.we == 3'b011 || bus.we == 3'b111);
    assign rise        = sync2 & ~prev;
    assign clr         = (wr && idx == 3'd3) ? bus.wdata[7:0] : 8'h00;
    assign unused_bits = ^{bus.addr[1:0], bus.wdata[XLEN-1:8]};
    assign gpio_out    = out_r & dir_r;
    assign gpio_oe     = dir_r;
    assign bus.rdata   = rdata_r;
    assign bus.hit     = hit_r;

    always_comb
        rd_val = idx == 3'd0 ? out_r  :
                 idx == 3'd1 ? dir_r  :
                 idx == 3'd2 ? sync2  :
                 idx == 3'd3 ? edge_r :
                 idx == 3'd4 ? mask_r : 8'h00;

    // A fresh edge is OR-ed in after the clear so it survives a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r   <= '0;
            dir_r   <= '0;
            edge_r  <= '0;
            sync1   <= '0;
            sync2   <= '0;
            prev    <= '0;
            rdata_r <= '0;
            hit_r   <= 1'b0;
        end else begin
            sync1   <= gpio_in;
            sync2   <= sync1;
            prev    <= sync2;
            edge_r  <= (edge_r & ~clr) | rise;
            if (wr && idx == 3'd0) out_r <= bus.wdata[7:0];
            if (wr && idx == 3'd1) dir_r <= bus.wdata[7:0];
            rdata_r <= sel ? {{(XLEN-8){1'b0}}, rd_val} : '0;
            hit_r   <= sel;
        end
    end

`ifdef GPIO_IRQ_EN
    logic irq_r;
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_r <= '0;
            irq_r  <= 1'b0;
        end else begin
            if (wr && idx == 3'd4) mask_r <= bus.wdata[7:0];
            irq_r <= |(edge_r & mask_r);
        end
    end
    assign irq = irq_r;
`else
    assign mask_r = 8'h00;
    assign irq    = 1'b0;
`endif
endmodule
